ev_injector: RTL and testbench

Injects processor-supplied event codes into the EVG transmit stream, the counterpart of the event logger that extracts codes from that stream. It sits in the `evgTxClk` domain between the sequencer output and the transceiver. It queues software event codes in a small FIFO and substitutes each one into the next free event slot, meaning a non-K null low byte. Upstream events always take priority. The distributed-bus upper byte is never altered.

---
 rtl/ev_injector.sv | 111 +++++++++++
 tb/tb_ev_injector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ev_injector.sv
// Event-code injector: queues software event codes and substitutes them into
// free (non-K, null) event slots of the EVG transmit stream, one cycle latency.
module ev_injector #(
    parameter int    FIFO_AW = 4,
    parameter string DEBUG   = "false"
) (
    input  logic                 evgTxClk,
    input  logic                 evgTxReset,
    input  logic                 wrStrobe,
    input  logic [7:0]           wrCode,
    input  logic                 clearOverflow,
    input  logic [1:0]           evInCharIsK,
    input  logic [15:0]          evInData,
    output logic [1:0]           evOutCharIsK,
    output logic [15:0]          evOutData,
    output logic                 wrFull,
    output logic                 overflow,
    output logic [FIFO_AW:0]     fifoCount,
    output logic [15:0]          injectCount
);

    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         fifoMem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr;
    logic [FIFO_AW-1:0] rdPtr;
    logic [FIFO_AW:0]   countNext;
    logic               slotFree;
    logic               fifoEmpty;
    logic               fifoFullNow;
    logic               codeValid;
    logic               doPush;
    logic               doPop;
    logic               doDrop;
    logic [7:0]         headCode;
    logic [7:0]         lowByte;

    assign slotFree    = ~evInCharIsK[0] && (evInData[7:0] == 8'h00);
    assign fifoEmpty   = (fifoCount == '0);
    // Fullness uses the pre-cycle count, so a same-cycle pop never rescues a write.
    assign fifoFullNow = (fifoCount == FULL_COUNT);
    assign codeValid   = wrStrobe && (wrCode != 8'h00);
    assign doPush      = codeValid && !fifoFullNow;
    assign doDrop      = codeValid && fifoFullNow;
    assign doPop       = slotFree && !fifoEmpty;

    assign headCode = fifoMem[rdPtr];
    assign lowByte  = doPop ? headCode : evInData[7:0];

    always_comb begin
        countNext = fifoCount;
        if (doPush && !doPop) begin
            countNext = fifoCount + 1'b1;
        end else if (doPop && !doPush) begin
            countNext = fifoCount - 1'b1;
        end
    end

    // FIFO storage carries data only; pointers and count define its validity.
    always_ff @(posedge evgTxClk) begin
        if (doPush) begin
            fifoMem[wrPtr] <= wrCode;
        end
    end

    // Output stage: stream registers and status, one edge after sampling.
    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            evOutData    <= '0;
            evOutCharIsK <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            fifoCount    <= '0;
            wrFull       <= 1'b0;
            overflow     <= 1'b0;
            injectCount  <= '0;
        end else begin
            evOutData    <= {evInData[15:8], lowByte};
            evOutCharIsK <= evInCharIsK;
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr       <= rdPtr + 1'b1;
                injectCount <= injectCount + 16'd1;
            end
            fifoCount <= countNext;
            wrFull    <= (countNext == FULL_COUNT);
            if (doDrop) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

    generate
        if (DEBUG == "true") begin : gDebug
            (* mark_debug = "true" *) logic [FIFO_AW-1:0] dbgWrPtr;
            (* mark_debug = "true" *) logic [FIFO_AW-1:0] dbgRdPtr;
            (* mark_debug = "true" *) logic               dbgPop;
            (* mark_debug = "true" *) logic               dbgPush;
            assign dbgWrPtr = wrPtr;
            assign dbgRdPtr = rdPtr;
            assign dbgPop   = doPop;
            assign dbgPush  = doPush;
        end
    endgenerate

endmodule

// File: tb/tb_ev_injector.sv
// Directed bench for ev_injector: a queue-based model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_ev_injector;

    logic        evgTxClk = 1'b0;
    logic        evgTxReset;
    logic        wrStrobe;
    logic [7:0]  wrCode;
    logic        clearOverflow;
    logic [1:0]  evInCharIsK;
    logic [15:0] evInData;
    logic [1:0]  evOutCharIsK;
    logic [15:0] evOutData;
    logic        wrFull;
    logic        overflow;
    logic [4:0]  fifoCount;
    logic [15:0] injectCount;

    always #5 evgTxClk = ~evgTxClk;

    ev_injector #(.FIFO_AW(4), .DEBUG("false")) dut (
        .evgTxClk      (evgTxClk),
        .evgTxReset    (evgTxReset),
        .wrStrobe      (wrStrobe),
        .wrCode        (wrCode),
        .clearOverflow (clearOverflow),
        .evInCharIsK   (evInCharIsK),
        .evInData      (evInData),
        .evOutCharIsK  (evOutCharIsK),
        .evOutData     (evOutData),
        .wrFull        (wrFull),
        .overflow      (overflow),
        .fifoCount     (fifoCount),
        .injectCount   (injectCount)
    );

    int nVec = 0;
    int nErr = 0;
    bit chk  = 1'b0;

    logic [7:0]  q[$];
    logic [15:0] expData;
    logic [1:0]  expK;
    logic        expOvf;
    logic [15:0] expInj;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        expData = '0;
        expK    = '0;
        expOvf  = 1'b0;
        expInj  = '0;
    endtask

    // Model: evaluate the rules on the inputs present before the edge, commit after it.
    task automatic cycle();
        logic        free, full, pop, nz;
        logic [7:0]  low;
        logic [15:0] nd;
        logic [1:0]  nk;
        free = !evInCharIsK[0] && (evInData[7:0] == 8'h00);
        full = (q.size() == 16);
        pop  = free && (q.size() > 0);
        low  = evInData[7:0];
        if (pop) low = q[0];
        nz   = wrStrobe && (wrCode != 8'h00);
        nd   = {evInData[15:8], low};
        nk   = evInCharIsK;
        @(posedge evgTxClk);
        #1;
        if (evgTxReset) return;
        expData = nd;
        expK    = nk;
        if (pop) begin
            void'(q.pop_front());
            expInj = expInj + 16'd1;
        end
        if (nz && !full) q.push_back(wrCode);
        if (nz && full) expOvf = 1'b1;
        else if (clearOverflow) expOvf = 1'b0;
    endtask

    task automatic drive(input logic [1:0] k, input logic [15:0] d, input logic s,
                         input logic [7:0] c, input logic cl);
        evInCharIsK   = k;
        evInData      = d;
        wrStrobe      = s;
        wrCode        = c;
        clearOverflow = cl;
        cycle();
    endtask

    task automatic asyncReset();
        #1;
        evgTxReset = 1'b1;
        modelReset();
        #1;
        check("rst evOutData", 32'(evOutData), 32'h0);
        check("rst evOutCharIsK", 32'(evOutCharIsK), 32'h0);
        check("rst fifoCount", 32'(fifoCount), 32'h0);
        check("rst injectCount", 32'(injectCount), 32'h0);
    endtask

    always @(negedge evgTxClk) begin
        if (chk) begin
            check("evOutData", 32'(evOutData), 32'(expData));
            check("evOutCharIsK", 32'(evOutCharIsK), 32'(expK));
            check("fifoCount", 32'(fifoCount), 32'(q.size()));
            check("wrFull", 32'(wrFull), 32'(q.size() == 16));
            check("overflow", 32'(overflow), 32'(expOvf));
            check("injectCount", 32'(injectCount), 32'(expInj));
        end
    end

    initial begin
        evgTxReset    = 1'b0;
        wrStrobe      = 1'b0;
        wrCode        = 8'h00;
        clearOverflow = 1'b0;
        evInCharIsK   = 2'b00;
        evInData      = 16'h0000;
        #1;
        evgTxReset = 1'b1;
        modelReset();
        chk = 1'b1;
        repeat (2) drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        evgTxReset = 1'b0;

        // Reset idle
        drive(2'b00, 16'h5A00, 1'b0, 8'h00, 1'b0);
        check("idle evOutData", 32'(evOutData), 32'h5A00);
        check("idle fifoCount", 32'(fifoCount), 32'h0);
        check("idle overflow", 32'(overflow), 32'h0);
        check("idle wrFull", 32'(wrFull), 32'h0);
        check("idle injectCount", 32'(injectCount), 32'h0);

        // Basic injection
        drive(2'b00, 16'hA500, 1'b1, 8'h22, 1'b0);
        check("basic count1", 32'(fifoCount), 32'h1);
        drive(2'b00, 16'hA500, 1'b1, 8'h33, 1'b0);
        check("basic out22", 32'(evOutData), 32'hA522);
        drive(2'b00, 16'hA500, 1'b0, 8'h00, 1'b0);
        check("basic out33", 32'(evOutData), 32'hA533);
        check("basic injectCount", 32'(injectCount), 32'h2);
        check("basic fifoCount", 32'(fifoCount), 32'h0);

        // Upstream priority
        drive(2'b00, 16'h0001, 1'b1, 8'h44, 1'b0);
        check("prio out01", 32'(evOutData), 32'h0001);
        drive(2'b01, 16'h00BC, 1'b0, 8'h00, 1'b0);
        check("prio outK", 32'(evOutData), 32'h00BC);
        check("prio K", 32'(evOutCharIsK), 32'h1);
        check("prio held", 32'(fifoCount), 32'h1);
        drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("prio out44", 32'(evOutData), 32'h0044);
        check("prio popped", 32'(fifoCount), 32'h0);

        // Full and overflow
        for (int i = 0; i < 17; i++) drive(2'b00, 16'h0007, 1'b1, 8'(8'h80 + i), 1'b0);
        check("full count", 32'(fifoCount), 32'd16);
        check("full wrFull", 32'(wrFull), 32'h1);
        check("full overflow", 32'(overflow), 32'h1);
        drive(2'b00, 16'h0007, 1'b0, 8'h00, 1'b1);
        check("clear overflow", 32'(overflow), 32'h0);
        drive(2'b00, 16'h0007, 1'b1, 8'h99, 1'b1);
        check("set wins", 32'(overflow), 32'h1);
        drive(2'b00, 16'h0007, 1'b0, 8'h00, 1'b1);
        drive(2'b00, 16'h0000, 1'b1, 8'hAA, 1'b0);
        check("no rescue out", 32'(evOutData), 32'h0080);
        check("no rescue count", 32'(fifoCount), 32'd15);
        check("no rescue ovf", 32'(overflow), 32'h1);
        repeat (15) drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("drain last", 32'(evOutData), 32'h008F);
        check("drain injectCount", 32'(injectCount), 32'd19);
        drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("17th dropped", 32'(evOutData), 32'h0000);

        // Simultaneous push/pop and pointer wrap
        asyncReset();
        drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        evgTxReset = 1'b0;
        for (int i = 1; i <= 3; i++) drive(2'b00, 16'h0009, 1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(2'b00, 16'h3C00, 1'b1, 8'(8'h10 + i), 1'b0);
            check("wrap steady count", 32'(fifoCount), 32'd3);
        end
        repeat (3) drive(2'b00, 16'h3C00, 1'b0, 8'h00, 1'b0);
        check("wrap last", 32'(evOutData), 32'h3C37);
        check("wrap injectCount", 32'(injectCount), 32'd43);
        check("wrap drained", 32'(fifoCount), 32'h0);

        // Mid-operation reset, then zero-code writes
        drive(2'b00, 16'h0009, 1'b1, 8'h55, 1'b0);
        drive(2'b00, 16'h0009, 1'b1, 8'h66, 1'b0);
        asyncReset();
        drive(2'b00, 16'h0000, 1'b1, 8'h77, 1'b0);
        evgTxReset = 1'b0;
        drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("post rst out", 32'(evOutData), 32'h0000);
        check("post rst count", 32'(fifoCount), 32'h0);
        drive(2'b00, 16'h0009, 1'b1, 8'h00, 1'b0);
        check("zero write count", 32'(fifoCount), 32'h0);
        for (int i = 0; i < 16; i++) drive(2'b00, 16'h0009, 1'b1, 8'(8'hC0 + i), 1'b0);
        drive(2'b00, 16'h0009, 1'b1, 8'h00, 1'b0);
        check("zero full count", 32'(fifoCount), 32'd16);
        check("zero full ovf", 32'(overflow), 32'h0);
        drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("first after zero", 32'(evOutData), 32'h00C0);
        repeat (16) drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0);
        check("final drained", 32'(fifoCount), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
